// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared FSM state type, default write latency and index-width helper for the FIFO write arbiter
package fifo_arb_pkg;
  typedef enum logic [1:0] {IDLE, WRITE, ACK} arb_state_e;
  localparam int DEF_WRITE_CYCLES = 2;
  // Index width that stays at least 1 bit even for a single-entry range
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_priority_select.sv
// rr_priority_select: combinational round-robin pick of the first set request starting at prio
//   i_req      request vector
//   i_prio     index where the search starts (wraps past N-1 to 0)
//   o_valid    any request set
//   o_winner   index of the selected request
module rr_priority_select import fifo_arb_pkg::*; #(
  parameter int N  = 3,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_prio,
  output logic          o_valid,
  output logic [IW-1:0] o_winner
);
  int w_j;
  // Scan offsets from farthest to nearest so the nearest set request overwrites the rest
  always_comb begin
    o_valid  = 1'b0;
    o_winner = '0;
    w_j      = 0;
    for (int i = N - 1; i >= 0; i--) begin
      w_j = int'(i_prio) + i;
      w_j = (w_j >= N) ? w_j - N : w_j;
      if (i_req[w_j]) begin
        o_valid  = 1'b1;
        o_winner = IW'(w_j);
      end
    end
  end
endmodule

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin sharing of one FIFO write port among NUM_REQ producers
//   i_clock, i_reset_n   clock, synchronous active-low reset
//   i_enable             allow new grants (an in-flight word always completes)
//   i_req, i_req_data    per-producer level request and packed data words
//   i_fifo_full          FIFO full flag, checked only at grant time
//   o_ack                one-cycle pulse to the grantee when its word is committed
//   o_grant_id           current/last grantee index
//   o_busy               word in flight (WRITE or ACK)
//   o_fifo_write_en      write enable, held WRITE_CYCLES cycles per word
//   o_fifo_write_data    registered word for FIFO storage
module fifo_write_arbiter import fifo_arb_pkg::*; #(
  parameter int NUM_REQ      = 3,
  parameter int DATA_WIDTH   = 8,
  parameter int WRITE_CYCLES = DEF_WRITE_CYCLES
) (
  input  logic                          i_clock,
  input  logic                          i_reset_n,
  input  logic                          i_enable,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  input  logic                          i_fifo_full,
  output logic [NUM_REQ-1:0]            o_ack,
  output logic [idx_w(NUM_REQ)-1:0]     o_grant_id,
  output logic                          o_busy,
  output logic                          o_fifo_write_en,
  output logic [DATA_WIDTH-1:0]         o_fifo_write_data
);
  localparam int IW = idx_w(NUM_REQ);
  localparam int CW = idx_w(WRITE_CYCLES);
  arb_state_e        r_state, w_next;
  logic [IW-1:0]     r_prio, r_grant_id, w_winner;
  logic [CW-1:0]     r_cnt;
  logic [DATA_WIDTH-1:0] r_data;
  logic              w_valid, w_start, w_last;
  rr_priority_select #(.N(NUM_REQ), .IW(IW)) u_sel (
    .i_req   (i_req),
    .i_prio  (r_prio),
    .o_valid (w_valid),
    .o_winner(w_winner)
  );
  assign w_start = i_enable && !i_fifo_full && w_valid;
  assign w_last  = (r_cnt == CW'(WRITE_CYCLES - 1));
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = w_start ? WRITE : IDLE;
      WRITE:   w_next = w_last ? ACK : WRITE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_state    <= IDLE;
      r_prio     <= '0;
      r_grant_id <= '0;
      r_data     <= '0;
      r_cnt      <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_start) begin
        r_grant_id <= w_winner;
        r_data     <= i_req_data[w_winner*DATA_WIDTH +: DATA_WIDTH];
        r_cnt      <= '0;
      end else if (r_state == WRITE) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (r_state == ACK)
        r_prio <= (r_grant_id == IW'(NUM_REQ - 1)) ? '0 : r_grant_id + IW'(1);
    end
  end
  assign o_busy            = (r_state != IDLE);
  assign o_fifo_write_en   = (r_state == WRITE);
  assign o_ack             = (r_state == ACK) ? (NUM_REQ'(1) << r_grant_id) : '0;
  assign o_grant_id        = r_grant_id;
  assign o_fifo_write_data = r_data;
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: directed self-checking bench for fifo_write_arbiter
module tb_fifo_write_arbiter;
  logic        clk = 1'b0;
  logic        rst_n, en, full;
  logic [2:0]  req;
  logic [23:0] rdata;
  logic [2:0]  ack;
  logic [1:0]  gid;
  logic        busy, we;
  logic [7:0]  wdata;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  fifo_write_arbiter #(.NUM_REQ(3), .DATA_WIDTH(8), .WRITE_CYCLES(2)) dut (
    .i_clock          (clk),
    .i_reset_n        (rst_n),
    .i_enable         (en),
    .i_req            (req),
    .i_req_data       (rdata),
    .i_fifo_full      (full),
    .o_ack            (ack),
    .o_grant_id       (gid),
    .o_busy           (busy),
    .o_fifo_write_en  (we),
    .o_fifo_write_data(wdata)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic st(input string tag, input logic e_we, input logic [2:0] e_ack, input logic e_busy);
    chk({tag, ".we"}, 32'(we), 32'(e_we));
    chk({tag, ".ack"}, 32'(ack), 32'(e_ack));
    chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
  endtask
  task automatic gnt(input string tag, input logic [1:0] e_gid, input logic [7:0] e_data);
    chk({tag, ".gid"}, 32'(gid), 32'(e_gid));
    chk({tag, ".data"}, 32'(wdata), 32'(e_data));
  endtask
  initial begin
    rst_n = 1'b0; en = 1'b1; full = 1'b0; req = 3'b000;
    rdata = {8'hCC, 8'hA5, 8'hAA};
    tick(); tick();
    st("rst", 1'b0, 3'b000, 1'b0);
    gnt("rst", 2'd0, 8'h00);
    rst_n = 1'b1;
    // single request from producer 1
    req = 3'b010;
    tick(); st("single.w1", 1'b1, 3'b000, 1'b1); gnt("single", 2'd1, 8'hA5);
    tick(); st("single.w2", 1'b1, 3'b000, 1'b1);
    tick(); st("single.ack", 1'b0, 3'b010, 1'b1);
    req = 3'b000;
    tick(); st("single.idle", 1'b0, 3'b000, 1'b0); gnt("single.hold", 2'd1, 8'hA5);
    // reset to bring prio back to 0, then contention
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    req = 3'b111;
    tick(); st("cont0.w1", 1'b1, 3'b000, 1'b1); gnt("cont0", 2'd0, 8'hAA);
    tick(); tick(); st("cont0.ack", 1'b0, 3'b001, 1'b1);
    req = 3'b110;
    tick(); st("cont0.idle", 1'b0, 3'b000, 1'b0);
    tick(); st("cont1.w1", 1'b1, 3'b000, 1'b1); gnt("cont1", 2'd1, 8'hA5);
    tick(); tick(); st("cont1.ack", 1'b0, 3'b010, 1'b1);
    req = 3'b100;
    tick(); st("cont1.idle", 1'b0, 3'b000, 1'b0);
    tick(); gnt("cont2", 2'd2, 8'hCC);
    tick(); tick(); st("cont2.ack", 1'b0, 3'b100, 1'b1);
    req = 3'b000;
    tick();
    // fairness wrap: prio back at 0
    req = 3'b101;
    tick(); gnt("wrap0", 2'd0, 8'hAA);
    tick(); tick(); st("wrap0.ack", 1'b0, 3'b001, 1'b1);
    req = 3'b100;
    tick(); tick(); gnt("wrap2", 2'd2, 8'hCC);
    tick(); tick(); st("wrap2.ack", 1'b0, 3'b100, 1'b1);
    req = 3'b000;
    tick();
    // full blocks grant; prio is 0
    full = 1'b1; req = 3'b001;
    tick(); st("full.1", 1'b0, 3'b000, 1'b0);
    tick(); st("full.2", 1'b0, 3'b000, 1'b0);
    full = 1'b0;
    tick(); st("full.go", 1'b1, 3'b000, 1'b1); gnt("full", 2'd0, 8'hAA);
    full = 1'b1;
    tick(); st("full.w2", 1'b1, 3'b000, 1'b1);
    tick(); st("full.ack", 1'b0, 3'b001, 1'b1);
    full = 1'b0; req = 3'b000;
    tick();
    // reset mid-WRITE with prio at 1
    req = 3'b011;
    tick(); st("rmid.w1", 1'b1, 3'b000, 1'b1); gnt("rmid", 2'd1, 8'hA5);
    rst_n = 1'b0;
    tick(); st("rmid.rst", 1'b0, 3'b000, 1'b0); gnt("rmid.rst", 2'd0, 8'h00);
    rst_n = 1'b1;
    tick(); st("rmid.re", 1'b1, 3'b000, 1'b1); gnt("rmid.re", 2'd0, 8'hAA);
    tick(); tick(); st("rmid.ack", 1'b0, 3'b001, 1'b1);
    req = 3'b000;
    tick(); st("rmid.idle", 1'b0, 3'b000, 1'b0);
    // enable low during WRITE; prio is 1
    req = 3'b010;
    tick(); gnt("en.g1", 2'd1, 8'hA5);
    en = 1'b0; req = 3'b110;
    tick(); st("en.w2", 1'b1, 3'b000, 1'b1);
    tick(); st("en.ack", 1'b0, 3'b010, 1'b1);
    req = 3'b100;
    tick(); st("en.idle1", 1'b0, 3'b000, 1'b0);
    tick(); st("en.idle2", 1'b0, 3'b000, 1'b0);
    en = 1'b1;
    tick(); st("en.go", 1'b1, 3'b000, 1'b1); gnt("en.g2", 2'd2, 8'hCC);
    tick(); tick(); st("en.ack2", 1'b0, 3'b100, 1'b1);
    req = 3'b000;
    tick(); st("end", 1'b0, 3'b000, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
